// File: rtl/credit_start_sequencer.sv
// Credit/start sequencer: expands coin/start requests into frame-timed
// coin -> gap -> start -> cooldown pulses for the galaxian core.
module credit_start_sequencer #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4,
  parameter int COOL_FRAMES  = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic vblank,
  input  logic req_start1,
  input  logic req_start2,
  input  logic req_coin,
  output logic coin_o,
  output logic start1_o,
  output logic start2_o,
  output logic busy_o
);

  localparam int M1   = (COIN_FRAMES > GAP_FRAMES) ? COIN_FRAMES : GAP_FRAMES;
  localparam int M2   = (START_FRAMES > COOL_FRAMES) ? START_FRAMES : COOL_FRAMES;
  localparam int MAXF = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXF + 1);

  localparam logic [CW-1:0] C_COIN  = CW'(COIN_FRAMES);
  localparam logic [CW-1:0] C_GAP   = CW'(GAP_FRAMES);
  localparam logic [CW-1:0] C_START = CW'(START_FRAMES);
  localparam logic [CW-1:0] C_COOL  = CW'(COOL_FRAMES);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START,
    S_COOL
  } state_t;

  typedef enum logic [1:0] {
    SEL_P1,
    SEL_P2,
    SEL_C
  } sel_t;

  state_t        r_state;
  sel_t          r_sel;
  logic [CW-1:0] r_cnt;

  logic r_vb_q;
  logic r_s1_q;
  logic r_s2_q;
  logic r_c_q;
  logic r_p1;
  logic r_p2;
  logic r_pc;

  logic w_tick;
  logic w_rise1;
  logic w_rise2;
  logic w_risec;
  logic w_idle;
  logic w_clr1;
  logic w_clr2;
  logic w_clrc;
  logic w_last;

  assign w_tick  = vblank & ~r_vb_q;
  assign w_rise1 = req_start1 & ~r_s1_q;
  assign w_rise2 = req_start2 & ~r_s2_q;
  assign w_risec = req_coin & ~r_c_q;

  // Priority p1 > p2 > coin-only; only the winner is cleared on IDLE exit
  assign w_idle = (r_state == S_IDLE);
  assign w_clr1 = w_idle & r_p1;
  assign w_clr2 = w_idle & ~r_p1 & r_p2;
  assign w_clrc = w_idle & ~r_p1 & ~r_p2 & r_pc;
  assign w_last = w_tick & (r_cnt == C_ONE);

  always_ff @(posedge clk_sys) begin
    r_vb_q <= vblank;
    r_s1_q <= req_start1;
    r_s2_q <= req_start2;
    r_c_q  <= req_coin;
    if (reset) begin
      r_state  <= S_IDLE;
      r_sel    <= SEL_P1;
      r_cnt    <= '0;
      r_p1     <= 1'b0;
      r_p2     <= 1'b0;
      r_pc     <= 1'b0;
      coin_o   <= 1'b0;
      start1_o <= 1'b0;
      start2_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      r_p1 <= (r_p1 & ~w_clr1) | (w_rise1 & ~r_p1);
      r_p2 <= (r_p2 & ~w_clr2) | (w_rise2 & ~r_p2);
      r_pc <= (r_pc & ~w_clrc) | (w_risec & ~r_pc);
      unique case (r_state)
        S_IDLE: begin
          if (r_p1 | r_p2 | r_pc) begin
            r_state <= S_COIN;
            r_cnt   <= C_COIN;
            coin_o  <= 1'b1;
            busy_o  <= 1'b1;
            if (r_p1)      r_sel <= SEL_P1;
            else if (r_p2) r_sel <= SEL_P2;
            else           r_sel <= SEL_C;
          end
        end
        S_COIN: begin
          if (w_last) begin
            coin_o <= 1'b0;
            if (r_sel == SEL_C) begin
              r_state <= S_COOL;
              r_cnt   <= C_COOL;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= C_GAP;
            end
          end else if (w_tick) begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_GAP: begin
          if (w_last) begin
            r_state  <= S_START;
            r_cnt    <= C_START;
            start1_o <= (r_sel == SEL_P1);
            start2_o <= (r_sel == SEL_P2);
          end else if (w_tick) begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_START: begin
          if (w_last) begin
            r_state  <= S_COOL;
            r_cnt    <= C_COOL;
            start1_o <= 1'b0;
            start2_o <= 1'b0;
          end else if (w_tick) begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_COOL: begin
          if (w_last) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end else if (w_tick) begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          coin_o   <= 1'b0;
          start1_o <= 1'b0;
          start2_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_credit_start_sequencer.sv
// Directed bench for credit_start_sequencer; outputs are compared as
// {coin, start1, start2, busy} against a frame-indexed timeline model.
module tb_credit_start_sequencer;

  logic clk_sys = 1'b0;
  logic reset;
  logic vblank;
  logic req_start1;
  logic req_start2;
  logic req_coin;
  logic coin_o;
  logic start1_o;
  logic start2_o;
  logic busy_o;
  logic [3:0] obs;

  int n_chk  = 0;
  int n_pass = 0;

  credit_start_sequencer dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vblank     (vblank),
    .req_start1 (req_start1),
    .req_start2 (req_start2),
    .req_coin   (req_coin),
    .coin_o     (coin_o),
    .start1_o   (start1_o),
    .start2_o   (start2_o),
    .busy_o     (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  assign obs = {coin_o, start1_o, start2_o, busy_o};

  // kind 0 = P1, 1 = P2, 2 = coin only; i = ticks since coin rose
  function automatic logic [3:0] seq_exp(input int kind, input int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i < 4)       v = 4'b1001;
    else if (kind == 2) begin
      if (i < 12)    v = 4'b0001;
    end else begin
      if (i < 12)      v = 4'b0001;
      else if (i < 16) v = (kind == 0) ? 4'b0101 : 4'b0011;
      else if (i < 24) v = 4'b0001;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic frame();
    vblank = 1'b1;
    @(negedge clk_sys);
    vblank = 1'b0;
    cyc(3);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: req_start1 = 1'b1;
      1: req_start2 = 1'b1;
      default: req_coin = 1'b1;
    endcase
    @(negedge clk_sys);
    req_start1 = 1'b0;
    req_start2 = 1'b0;
    req_coin   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset      = 1'b1;
    vblank     = 1'b0;
    req_start1 = 1'b1;
    req_start2 = 1'b0;
    req_coin   = 1'b0;

    // held-high request across reset release must not fire
    cyc(3);
    chk("rst_state", obs, 4'b0000);
    reset = 1'b0;
    cyc(3);
    chk("held_no_fire", obs, 4'b0000);
    frame();
    frame();
    chk("held_no_fire_fr", obs, 4'b0000);
    req_start1 = 1'b0;
    @(negedge clk_sys);
    req_start1 = 1'b1;
    @(negedge clk_sys);
    chk("lat_k", obs, 4'b0000);
    @(negedge clk_sys);
    chk("lat_k1", obs, 4'b1001);
    req_start1 = 1'b0;
    do_reset();

    // single P1 sequence, 24 ticks
    pulse(0);
    cyc(1);
    chk("p1 f0", obs, seq_exp(0, 0));
    for (int i = 1; i <= 26; i++) begin
      frame();
      chk($sformatf("p1 f%0d", i), obs, seq_exp(0, i));
    end

    // simultaneous P1 and P2 rises
    do_reset();
    req_start1 = 1'b1;
    req_start2 = 1'b1;
    @(negedge clk_sys);
    req_start1 = 1'b0;
    req_start2 = 1'b0;
    cyc(1);
    chk("both f0", obs, seq_exp(0, 0));
    for (int i = 1; i <= 50; i++) begin
      frame();
      chk($sformatf("both f%0d", i), obs,
          (i < 24) ? seq_exp(0, i) : seq_exp(1, i - 24));
    end

    // coin only
    do_reset();
    pulse(2);
    cyc(1);
    chk("coin f0", obs, seq_exp(2, 0));
    for (int i = 1; i <= 14; i++) begin
      frame();
      chk($sformatf("coin f%0d", i), obs, seq_exp(2, i));
    end

    // three P2 rises during one P1 sequence -> one P2 sequence
    do_reset();
    pulse(0);
    cyc(1);
    for (int i = 1; i <= 58; i++) begin
      if (i == 2 || i == 6 || i == 10) pulse(1);
      frame();
      chk($sformatf("p2x3 f%0d", i), obs,
          (i < 24) ? seq_exp(0, i) : seq_exp(1, i - 24));
    end

    // no vblank activity: state and outputs hold
    do_reset();
    pulse(0);
    cyc(41);
    chk("stall coin", obs, 4'b1001);
    for (int i = 1; i <= 4; i++) frame();
    chk("stall f4", obs, seq_exp(0, 4));
    cyc(60);
    chk("stall gap", obs, 4'b0001);

    // reset during START with further requests pending
    do_reset();
    pulse(0);
    cyc(1);
    for (int i = 1; i <= 13; i++) frame();
    chk("mid start", obs, seq_exp(0, 13));
    pulse(1);
    pulse(2);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_now", obs, 4'b0000);
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      frame();
      chk($sformatf("post_rst f%0d", i), obs, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
